// File: rtl/hm3_gen_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined 3Y hard-multiple generator.
package hm3_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Control part of a pipeline token; the width-dependent fields live in the top.
  typedef struct packed {
    logic  valid;
    mode_e mode;
    logic  carry;
  } tok_ctl_t;

  function automatic int ext_w(input int w);
    return w + 2;
  endfunction

  function automatic int nseg(input int w, input int seg);
    return (ext_w(w) + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/hm3_gen_pipe_if.sv
// Operand-in / result-out handshake bundle of the 3Y generator.
interface hm3_gen_pipe_if #(
  parameter int W     = 16,
  parameter int OUT_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_y;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_s;
  logic             out_approx;

  modport master (
    output in_valid, in_y, in_approx, out_ready,
    input  in_ready, out_valid, out_s, out_approx
  );

  modport slave (
    input  in_valid, in_y, in_approx, out_ready,
    output in_ready, out_valid, out_s, out_approx
  );
endinterface

// File: rtl/hm3_gen_pipe_seg_add.sv
// One SEG-bit slice of A+B where masked bits use the OR rule and emit a&b as carry.
module hm3_seg_add #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic [SEG-1:0] m,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = m[i] ? (a[i] | b[i]) : (a[i] ^ b[i] ^ c[i]);
      // Inside the approximate region no carry ripples; only the top masked bit's a&b escapes.
      c[i+1] = m[i] ? (a[i] & b[i]) : ((a[i] & b[i]) | (c[i] & (a[i] ^ b[i])));
    end
    cout = c[SEG];
  end

endmodule

// File: rtl/hm3_gen_pipe.sv
// Pipelined signed 3Y = Y + 2Y generator, one SEG-bit segment per stage, optional lower-part-OR.
module hm3_gen_pipe
  import hm3_pkg::*;
#(
  parameter int W           = 16,
  parameter int APPROX_BITS = 8,
  parameter int SEG         = 8,
  parameter int OUT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  hm3_gen_pipe_if.slave bus
);

  localparam int E    = ext_w(W);
  localparam int NSEG = nseg(W, SEG);
  localparam int PE   = NSEG * SEG;

  typedef struct packed {
    tok_ctl_t      ctl;
    logic [PE-1:0] sum;
    logic [W-1:0]  y;
  } tok_t;

  tok_t            stg_q [NSEG];
  tok_t            stg_d [NSEG];
  tok_t            src   [NSEG];
  logic [NSEG-1:0] load;
  logic [PE-1:0]   op_a  [NSEG];
  logic [PE-1:0]   op_b  [NSEG];
  logic [SEG-1:0]  seg_a [NSEG];
  logic [SEG-1:0]  seg_b [NSEG];
  logic [SEG-1:0]  seg_m [NSEG];
  logic [SEG-1:0]  seg_s [NSEG];
  logic            seg_co[NSEG];
  logic signed [E-1:0] sum_e;

  // Load chain runs from the output backwards so bubbles collapse in one cycle.
  always_comb begin
    load[NSEG-1] = !stg_q[NSEG-1].ctl.valid || bus.out_ready;
    for (int j = NSEG - 2; j >= 0; j--) begin
      load[j] = !stg_q[j].ctl.valid || load[j+1];
    end

    src[0].ctl = '{valid: bus.in_valid, mode: mode_e'(bus.in_approx), carry: 1'b0};
    src[0].sum = '0;
    src[0].y   = bus.in_y;
    for (int j = 1; j < NSEG; j++) begin
      src[j] = stg_q[j-1];
    end

    for (int j = 0; j < NSEG; j++) begin
      op_a[j]  = {{(PE - W){src[j].y[W-1]}}, src[j].y};
      op_b[j]  = {op_a[j][PE-2:0], 1'b0};
      seg_a[j] = op_a[j][j*SEG +: SEG];
      seg_b[j] = op_b[j][j*SEG +: SEG];
      seg_m[j] = '0;
      for (int i = 0; i < SEG; i++) begin
        seg_m[j][i] = (src[j].ctl.mode == MODE_APPROX) && ((j * SEG + i) < APPROX_BITS);
      end
    end
  end

  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    hm3_seg_add #(.SEG(SEG)) u_seg (
      .a    (seg_a[j]),
      .b    (seg_b[j]),
      .m    (seg_m[j]),
      .cin  (src[j].ctl.carry),
      .s    (seg_s[j]),
      .cout (seg_co[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NSEG; j++) begin
      stg_d[j] = stg_q[j];
      if (load[j]) begin
        stg_d[j]                    = src[j];
        stg_d[j].sum[j*SEG +: SEG]  = seg_s[j];
        stg_d[j].ctl.carry          = seg_co[j];
      end
    end
  end

  // NOTE: whole tokens are reset, not just valid bits, so out_s and out_approx read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NSEG; j++) stg_q[j] <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each stage capture its neighbour's pre-edge value.
      for (int j = 0; j < NSEG; j++) stg_q[j] <= stg_d[j];
    end
  end

  assign sum_e          = stg_q[NSEG-1].sum[E-1:0];
  assign bus.in_ready   = load[0];
  assign bus.out_valid  = stg_q[NSEG-1].ctl.valid;
  assign bus.out_approx = (stg_q[NSEG-1].ctl.mode == MODE_APPROX);
  assign bus.out_s      = OUT_W'(sum_e);

endmodule

// File: tb/tb_hm3_gen_pipe.sv
// Bench for hm3_gen_pipe: directed cases on the default build, randomized streams on three other builds.
module tb_hm3_gen_pipe;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ND-1:0]       t_in_valid  = '0;
  logic [ND-1:0][15:0] t_in_y      = '0;
  logic [ND-1:0]       t_in_approx = '0;
  logic [ND-1:0]       t_out_ready = '0;
  logic [ND-1:0]       t_in_ready;
  logic [ND-1:0]       t_out_valid;
  logic [ND-1:0][31:0] t_out_s;
  logic [ND-1:0]       t_out_approx;

  hm3_gen_pipe_if #(.W(16), .OUT_W(32)) bus0 ();
  hm3_gen_pipe_if #(.W(12), .OUT_W(32)) bus1 ();
  hm3_gen_pipe_if #(.W(8),  .OUT_W(32)) bus2 ();
  hm3_gen_pipe_if #(.W(8),  .OUT_W(32)) bus3 ();

  assign bus0.in_valid = t_in_valid[0];  assign bus0.in_y = t_in_y[0];
  assign bus0.in_approx = t_in_approx[0]; assign bus0.out_ready = t_out_ready[0];
  assign t_in_ready[0] = bus0.in_ready;   assign t_out_valid[0] = bus0.out_valid;
  assign t_out_s[0] = bus0.out_s;         assign t_out_approx[0] = bus0.out_approx;

  assign bus1.in_valid = t_in_valid[1];  assign bus1.in_y = t_in_y[1][11:0];
  assign bus1.in_approx = t_in_approx[1]; assign bus1.out_ready = t_out_ready[1];
  assign t_in_ready[1] = bus1.in_ready;   assign t_out_valid[1] = bus1.out_valid;
  assign t_out_s[1] = bus1.out_s;         assign t_out_approx[1] = bus1.out_approx;

  assign bus2.in_valid = t_in_valid[2];  assign bus2.in_y = t_in_y[2][7:0];
  assign bus2.in_approx = t_in_approx[2]; assign bus2.out_ready = t_out_ready[2];
  assign t_in_ready[2] = bus2.in_ready;   assign t_out_valid[2] = bus2.out_valid;
  assign t_out_s[2] = bus2.out_s;         assign t_out_approx[2] = bus2.out_approx;

  assign bus3.in_valid = t_in_valid[3];  assign bus3.in_y = t_in_y[3][7:0];
  assign bus3.in_approx = t_in_approx[3]; assign bus3.out_ready = t_out_ready[3];
  assign t_in_ready[3] = bus3.in_ready;   assign t_out_valid[3] = bus3.out_valid;
  assign t_out_s[3] = bus3.out_s;         assign t_out_approx[3] = bus3.out_approx;

  hm3_gen_pipe #(.W(16), .APPROX_BITS(8), .SEG(8), .OUT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hm3_gen_pipe #(.W(12), .APPROX_BITS(5), .SEG(4), .OUT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  hm3_gen_pipe #(.W(8),  .APPROX_BITS(8), .SEG(3), .OUT_W(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  hm3_gen_pipe #(.W(8),  .APPROX_BITS(0), .SEG(5), .OUT_W(32)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Reference: 3Y as integer arithmetic on sign-extended values, low k bits OR'd in approximate mode.
  function automatic logic [31:0] ref3(input logic [15:0] y_raw, input logic ap, input int w, input int k);
    longint a, b, s, hi, lo, c, e_mask;
    a = longint'(y_raw) & ((longint'(1) <<< w) - 1);
    if (a[w-1]) a = a - (longint'(1) <<< w);
    b      = 2 * a;
    e_mask = (longint'(1) <<< (w + 2)) - 1;
    if (ap && k > 0) begin
      lo = (a | b) & ((longint'(1) <<< k) - 1);
      c  = (a >>> (k - 1)) & (b >>> (k - 1)) & 1;
      hi = (a >>> k) + (b >>> k) + c;
      s  = (hi <<< k) | lo;
    end else begin
      s = a + b;
    end
    s = s & e_mask;
    if (s[w+1]) s = s - (longint'(1) <<< (w + 2));
    return s[31:0];
  endfunction

  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (!t_out_valid[d] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t_in_valid = '0; t_out_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (t_out_valid[d] !== 1'b0 || t_out_s[d] !== 32'h0 || t_out_approx[d] !== 1'b0 ||
          t_in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: out_valid=%b out_s=%h out_approx=%b in_ready=%b, want 0 0 0 1",
                 d, t_out_valid[d], t_out_s[d], t_out_approx[d], t_in_ready[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] ys [9];
    logic        aps[9];
    logic [31:0] exs[9];
    int lat;
    ys[0] = 16'h00FF; aps[0] = 1'b0; exs[0] = 32'h0000_02FD;
    ys[1] = 16'h7FFF; aps[1] = 1'b0; exs[1] = 32'h0001_7FFD;
    ys[2] = 16'h8000; aps[2] = 1'b0; exs[2] = 32'hFFFE_8000;
    ys[3] = 16'h00FF; aps[3] = 1'b1; exs[3] = 32'h0000_02FF;
    ys[4] = 16'h0001; aps[4] = 1'b1; exs[4] = 32'h0000_0003;
    ys[5] = 16'hFFFF; aps[5] = 1'b1; exs[5] = 32'hFFFF_FFFF;
    ys[6] = 16'hFFFF; aps[6] = 1'b0; exs[6] = 32'hFFFF_FFFD;
    ys[7] = 16'h7FFF; aps[7] = 1'b1; exs[7] = 32'h0001_7FFF;
    ys[8] = 16'h8000; aps[8] = 1'b1; exs[8] = 32'hFFFE_8000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      t_in_valid[0] = 1'b1; t_in_y[0] = ys[i]; t_in_approx[0] = aps[i]; t_out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_in_valid[0] = 1'b0;
      #1;
      wait_out(0, lat);
      checks++;
      if (lat !== 3 || t_out_s[0] !== exs[i] || t_out_approx[0] !== aps[i]) begin
        errors++;
        $display("FAIL directed[%0d] y=%h ap=%b: latency=%0d out_s=%h tag=%b, want 3 %h %b",
                 i, ys[i], aps[i], lat, t_out_s[0], t_out_approx[0], exs[i], aps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ys[20];
    int oi = 0;
    for (int i = 0; i < 20; i++) ys[i] = 16'($urandom);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      t_out_ready[0] = 1'b1;
      t_in_valid[0]  = (cyc < 20);
      t_in_y[0]      = ys[cyc % 20];
      t_in_approx[0] = cyc[0];
      #1;
      if (cyc < 20) begin
        checks++;
        if (t_in_ready[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, t_in_ready[0]);
        end
      end
      if (t_out_valid[0]) begin
        checks++;
        if (oi >= 20 || cyc != oi + 3 || t_out_s[0] !== ref3(ys[oi % 20], oi[0], 16, 8) ||
            t_out_approx[0] !== oi[0]) begin
          errors++;
          $display("FAIL b2b_result[%0d] cyc%0d: out_s=%h tag=%b, want %h %b at cyc%0d",
                   oi, cyc, t_out_s[0], t_out_approx[0], ref3(ys[oi % 20], oi[0], 16, 8), oi[0], oi + 3);
        end
        oi++;
      end
    end
    t_in_valid[0] = 1'b0;
    checks++;
    if (oi != 20) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 20", oi);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ys[6];
    logic [31:0] hold_s = '0;
    logic        have_hold = 1'b0;
    int acc = 0;
    int oi = 0;
    for (int i = 0; i < 6; i++) ys[i] = 16'($urandom);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      t_in_valid[0] = 1'b1; t_in_y[0] = ys[acc]; t_in_approx[0] = acc[0]; t_out_ready[0] = 1'b0;
      #1;
      if (t_out_valid[0]) begin
        if (have_hold) begin
          checks++;
          if (t_out_s[0] !== hold_s) begin
            errors++;
            $display("FAIL bp_stable cyc%0d: out_s=%h want %h", cyc, t_out_s[0], hold_s);
          end
        end else begin
          hold_s = t_out_s[0];
          have_hold = 1'b1;
        end
      end
      if (t_in_ready[0]) acc++;
    end
    checks++;
    if (acc != 3 || t_in_ready[0] !== 1'b0 || t_out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: accepts=%0d in_ready=%b out_valid=%b, want 3 0 1", acc, t_in_ready[0], t_out_valid[0]);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      t_in_valid[0] = 1'b0; t_out_ready[0] = 1'b1;
      #1;
      if (t_out_valid[0]) begin
        checks++;
        if (oi >= 3 || cyc != oi || t_out_s[0] !== ref3(ys[oi % 6], oi[0], 16, 8) ||
            t_out_approx[0] !== oi[0]) begin
          errors++;
          $display("FAIL bp_drain[%0d] cyc%0d: out_s=%h tag=%b, want %h %b",
                   oi, cyc, t_out_s[0], t_out_approx[0], ref3(ys[oi % 6], oi[0], 16, 8), oi[0]);
        end
        oi++;
      end
    end
    checks++;
    if (oi != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 3", oi);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    t_in_valid[0] = 1'b1; t_in_y[0] = 16'h0011; t_in_approx[0] = 1'b0; t_out_ready[0] = 1'b0;
    @(negedge clk);
    t_in_y[0] = 16'h0022;
    @(negedge clk);
    t_in_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (t_out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: out_valid=%b want 1", t_out_valid[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (t_out_valid[0] !== 1'b0 || t_out_s[0] !== 32'h0 || t_in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: out_valid=%b out_s=%h in_ready=%b, want 0 0 1",
               t_out_valid[0], t_out_s[0], t_in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      t_out_ready[0] = 1'b1;
      #1;
      checks++;
      if (t_out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale cyc%0d: out_valid=%b out_s=%h want no output", cyc, t_out_valid[0], t_out_s[0]);
      end
    end
    @(negedge clk);
    t_in_valid[0] = 1'b1; t_in_y[0] = 16'h0003; t_in_approx[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    t_in_valid[0] = 1'b0;
    #1;
    wait_out(0, lat);
    checks++;
    if (lat !== 3 || t_out_s[0] !== 32'h0000_0009 || t_out_approx[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next: latency=%0d out_s=%h tag=%b, want 3 00000009 0", lat, t_out_s[0], t_out_approx[0]);
    end
  endtask

  typedef struct {
    logic [31:0] s;
    logic        ap;
  } exp_t;

  task automatic test_random(input int d, input int w, input int k, input int n);
    exp_t exp_q[$];
    exp_t e;
    int acc = 0;
    int cyc = 0;
    logic stall_prev = 1'b0;
    logic [31:0] prev_s = '0;
    logic prev_ap = 1'b0;
    while (acc < n && cyc < 4 * n + 100) begin
      @(negedge clk);
      t_in_valid[d]  = ($urandom_range(0, 3) != 0);
      t_in_y[d]      = 16'($urandom);
      t_in_approx[d] = 1'($urandom_range(0, 1));
      t_out_ready[d] = ($urandom_range(0, 3) != 0);
      #1;
      if (stall_prev) begin
        checks++;
        if (t_out_valid[d] !== 1'b1 || t_out_s[d] !== prev_s || t_out_approx[d] !== prev_ap) begin
          errors++;
          $display("FAIL rand_hold dut%0d cyc%0d: valid=%b out_s=%h tag=%b, want 1 %h %b",
                   d, cyc, t_out_valid[d], t_out_s[d], t_out_approx[d], prev_s, prev_ap);
        end
      end
      if (t_in_valid[d] && t_in_ready[d]) begin
        exp_q.push_back('{s: ref3(t_in_y[d], t_in_approx[d], w, k), ap: t_in_approx[d]});
        acc++;
      end
      if (t_out_valid[d] && t_out_ready[d]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra dut%0d cyc%0d: unexpected out_s=%h", d, cyc, t_out_s[d]);
        end else begin
          e = exp_q.pop_front();
          if (t_out_s[d] !== e.s || t_out_approx[d] !== e.ap) begin
            errors++;
            $display("FAIL rand_result dut%0d cyc%0d: out_s=%h tag=%b, want %h %b",
                     d, cyc, t_out_s[d], t_out_approx[d], e.s, e.ap);
          end
        end
      end
      stall_prev = t_out_valid[d] && !t_out_ready[d];
      prev_s     = t_out_s[d];
      prev_ap    = t_out_approx[d];
      cyc++;
    end
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL rand_accepts dut%0d: got %0d accepts want %0d within budget", d, acc, n);
    end
    for (int dc = 0; dc < 100 && exp_q.size() > 0; dc++) begin
      @(negedge clk);
      t_in_valid[d] = 1'b0; t_out_ready[d] = 1'b1;
      #1;
      if (t_out_valid[d]) begin
        e = exp_q.pop_front();
        checks++;
        if (t_out_s[d] !== e.s || t_out_approx[d] !== e.ap) begin
          errors++;
          $display("FAIL rand_drain dut%0d: out_s=%h tag=%b, want %h %b", d, t_out_s[d], t_out_approx[d], e.s, e.ap);
        end
      end
    end
    @(negedge clk);
    t_in_valid[d] = 1'b0;
    #1;
    checks++;
    if (exp_q.size() != 0 || t_out_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL rand_final dut%0d: pending=%0d out_valid=%b, want 0 0", d, exp_q.size(), t_out_valid[d]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random(1, 12, 5, 10000);
    test_random(2, 8, 8, 2000);
    test_random(3, 8, 0, 2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
